// File: rtl/dsp_mult_arbiter.sv
// Round-robin arbiter sharing one dot-product multiplier among NB_REQ requesters, returning ID-tagged results.
// Optional performance counters are enabled by defining DSP_MULT_ARB_PERF_EN.
module dsp_mult_arbiter #(
    parameter int NB_REQ      = 4,
    parameter int PIPE_STAGES = 1,
    parameter int ID_WIDTH    = $clog2(NB_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NB_REQ-1:0]      req_i,
    output logic [NB_REQ-1:0]      gnt_o,
    input  logic [NB_REQ-1:0][2:0]  operator_i,
    input  logic [NB_REQ-1:0][31:0] op_a_i,
    input  logic [NB_REQ-1:0][31:0] op_b_i,
    input  logic [NB_REQ-1:0][31:0] op_c_i,
    input  logic [NB_REQ-1:0][1:0]  dot_signed_i,
    output logic [NB_REQ-1:0]      rvalid_o,
    output logic [31:0]            result_o,
    output logic                   busy_o
`ifdef DSP_MULT_ARB_PERF_EN
    ,
    input  logic                   perf_clr_i,
    output logic [31:0]            perf_busy_o,
    output logic [31:0]            perf_conflict_o
`endif
);

    localparam logic [2:0] MUL_DOT8  = 3'b100;
    localparam logic [2:0] MUL_DOT16 = 3'b101;

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0] gnt_idx;
    logic                found;
    logic                accept;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        // First pass searches from the pointer upwards, second pass wraps around to index 0.
        for (int i = 0; i < NB_REQ; i++) begin
            if (!found && req_i[i] && (i >= int'(rr_ptr_q))) begin
                found   = 1'b1;
                gnt_idx = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < NB_REQ; i++) begin
            if (!found && req_i[i]) begin
                found   = 1'b1;
                gnt_idx = ID_WIDTH'(i);
            end
        end
        gnt_o = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            gnt_o[i] = found && !rst_i && (gnt_idx == ID_WIDTH'(i));
        end
        accept = |(req_i & gnt_o);
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == ID_WIDTH'(NB_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: operand register feeding the multiplier
    // ------------------------------------------------------------------
    logic                s0_valid_q, s0_valid_d;
    logic [ID_WIDTH-1:0] s0_id_q, s0_id_d;
    logic [2:0]          s0_op_q, s0_op_d;
    logic [31:0]         s0_a_q, s0_a_d;
    logic [31:0]         s0_b_q, s0_b_d;
    logic [31:0]         s0_c_q, s0_c_d;
    logic [1:0]          s0_sgn_q, s0_sgn_d;

    always_comb begin
        s0_valid_d = accept;
        s0_id_d    = s0_id_q;
        s0_op_d    = s0_op_q;
        s0_a_d     = s0_a_q;
        s0_b_d     = s0_b_q;
        s0_c_d     = s0_c_q;
        s0_sgn_d   = s0_sgn_q;
        if (accept) begin
            s0_id_d  = gnt_idx;
            s0_op_d  = operator_i[gnt_idx];
            s0_a_d   = op_a_i[gnt_idx];
            s0_b_d   = op_b_i[gnt_idx];
            s0_c_d   = op_c_i[gnt_idx];
            s0_sgn_d = dot_signed_i[gnt_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s0_valid_q <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are only observed when their valid bit is set, which is reset.
    always_ff @(posedge clk_i) begin
        s0_id_q  <= s0_id_d;
        s0_op_q  <= s0_op_d;
        s0_a_q   <= s0_a_d;
        s0_b_q   <= s0_b_d;
        s0_c_q   <= s0_c_d;
        s0_sgn_q <= s0_sgn_d;
    end

    // ------------------------------------------------------------------
    // Dot-product multiplier (combinational)
    // ------------------------------------------------------------------
    logic signed [8:0]  a8, b8;
    logic signed [17:0] p8;
    logic signed [16:0] a16, b16;
    logic signed [33:0] p16;
    logic [31:0]        dot8, dot16, dsp_res;

    always_comb begin
        a8    = '0;
        b8    = '0;
        p8    = '0;
        a16   = '0;
        b16   = '0;
        p16   = '0;
        dot8  = s0_c_q;
        dot16 = s0_c_q;
        // Each lane is widened by one bit so unsigned and signed lanes share one signed multiplier.
        for (int i = 0; i < 4; i++) begin
            a8   = {s0_sgn_q[1] & s0_a_q[8*i+7], s0_a_q[8*i +: 8]};
            b8   = {s0_sgn_q[0] & s0_b_q[8*i+7], s0_b_q[8*i +: 8]};
            p8   = 18'(a8) * 18'(b8);
            dot8 = dot8 + {{14{p8[17]}}, p8};
        end
        for (int i = 0; i < 2; i++) begin
            a16   = {s0_sgn_q[1] & s0_a_q[16*i+15], s0_a_q[16*i +: 16]};
            b16   = {s0_sgn_q[0] & s0_b_q[16*i+15], s0_b_q[16*i +: 16]};
            p16   = 34'(a16) * 34'(b16);
            dot16 = dot16 + p16[31:0];
        end
        unique case (s0_op_q)
            MUL_DOT8:  dsp_res = dot8;
            MUL_DOT16: dsp_res = dot16;
            default:   dsp_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result pipeline: index 0 is the multiplier output, 1..PIPE_STAGES are registers
    // ------------------------------------------------------------------
    logic [PIPE_STAGES:0]               stg_valid;
    logic [PIPE_STAGES:0][ID_WIDTH-1:0] stg_id;
    logic [PIPE_STAGES:0][31:0]         stg_res;

    assign stg_valid[0] = s0_valid_q;
    assign stg_id[0]    = s0_id_q;
    assign stg_res[0]   = dsp_res;

    for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_pipe
        logic                valid_q, valid_d;
        logic [ID_WIDTH-1:0] id_q, id_d;
        logic [31:0]         res_q, res_d;

        always_comb begin
            valid_d = stg_valid[k-1];
            id_d    = stg_id[k-1];
            res_d   = stg_res[k-1];
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
            end
        end

        always_ff @(posedge clk_i) begin
            id_q  <= id_d;
            res_q <= res_d;
        end

        assign stg_valid[k] = valid_q;
        assign stg_id[k]    = id_q;
        assign stg_res[k]   = res_q;
    end

    always_comb begin
        rvalid_o = '0;
        result_o = '0;
        if (stg_valid[PIPE_STAGES]) begin
            rvalid_o[stg_id[PIPE_STAGES]] = 1'b1;
            result_o                      = stg_res[PIPE_STAGES];
        end
        busy_o = |stg_valid;
    end

`ifdef DSP_MULT_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters; clear has priority over increment
    // ------------------------------------------------------------------
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic        conflict;

    always_comb begin
        conflict        = ($countones(req_i) > 1);
        perf_busy_d     = perf_busy_q;
        perf_conflict_d = perf_conflict_q;
        if (perf_clr_i) begin
            perf_busy_d     = '0;
            perf_conflict_d = '0;
        end else begin
            if (accept && (perf_busy_q != '1)) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
            if (conflict && (perf_conflict_q != '1)) begin
                perf_conflict_d = perf_conflict_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_busy_q     <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_busy_q     <= perf_busy_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_busy_o     = perf_busy_q;
    assign perf_conflict_o = perf_conflict_q;
`endif

endmodule

// File: tb/tb_dsp_mult_arbiter.sv
// Scoreboard bench for dsp_mult_arbiter: directed issues push expected results, a monitor pops them on rvalid_o.
// Performance counter checks are compiled in when DSP_MULT_ARB_PERF_EN is defined.
module tb_dsp_mult_arbiter;

    localparam int NB_REQ      = 4;
    localparam int PIPE_STAGES = 1;

    localparam logic [2:0] MUL_MAC32 = 3'b000;
    localparam logic [2:0] MUL_DOT8  = 3'b100;
    localparam logic [2:0] MUL_DOT16 = 3'b101;

    // Round-robin table: each requester issues twice, then drops its request.
    localparam logic [3:0]  REQ_TAB [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hC, 4'h8};
    localparam logic [3:0]  GNT_TAB [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    localparam logic [31:0] RES_TAB [8] = '{32'd4, 32'd9, 32'd14, 32'd19, 32'd4, 32'd9, 32'd14, 32'd19};

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NB_REQ-1:0]       req_i;
    logic [NB_REQ-1:0]       gnt_o;
    logic [NB_REQ-1:0][2:0]  operator_i;
    logic [NB_REQ-1:0][31:0] op_a_i;
    logic [NB_REQ-1:0][31:0] op_b_i;
    logic [NB_REQ-1:0][31:0] op_c_i;
    logic [NB_REQ-1:0][1:0]  dot_signed_i;
    logic [NB_REQ-1:0]       rvalid_o;
    logic [31:0]             result_o;
    logic                    busy_o;
`ifdef DSP_MULT_ARB_PERF_EN
    logic                    perf_clr_i;
    logic [31:0]             perf_busy_o;
    logic [31:0]             perf_conflict_o;
`endif

    dsp_mult_arbiter #(
        .NB_REQ      (NB_REQ),
        .PIPE_STAGES (PIPE_STAGES)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_i           (req_i),
        .gnt_o           (gnt_o),
        .operator_i      (operator_i),
        .op_a_i          (op_a_i),
        .op_b_i          (op_b_i),
        .op_c_i          (op_c_i),
        .dot_signed_i    (dot_signed_i),
        .rvalid_o        (rvalid_o),
        .result_o        (result_o),
        .busy_o          (busy_o)
`ifdef DSP_MULT_ARB_PERF_EN
        ,
        .perf_clr_i      (perf_clr_i),
        .perf_busy_o     (perf_busy_o),
        .perf_conflict_o (perf_conflict_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid result is matched against the oldest expectation, including its due cycle.
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (!rst_i) begin
            if (rvalid_o != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", {28'b0, rvalid_o}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("rvalid", {28'b0, rvalid_o}, {28'b0, e.vld});
                    check("result", result_o, e.res);
                    check("latency", 32'(cyc), 32'(e.due));
                end
            end else begin
                check("result_idle", result_o, 32'h0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [1:0] sgn);
        operator_i[idx]   = op;
        op_a_i[idx]       = a;
        op_b_i[idx]       = b;
        op_c_i[idx]       = c;
        dot_signed_i[idx] = sgn;
    endtask

    // Called one step after a rising edge; checks the combinational grant and queues the expected result.
    task automatic issue(input string name, input logic [3:0] req, input logic [3:0] exp_gnt,
                         input logic [31:0] exp_res, input bit push);
        req_i = req;
        #1;
        check(name, {28'b0, gnt_o}, {28'b0, exp_gnt});
        if (push && (exp_gnt != '0)) begin
            sb.push_back(exp_t'{exp_gnt, exp_res, cyc + 1 + PIPE_STAGES});
        end
        next_cycle();
    endtask

    initial begin
        rst_i        = 1'b1;
        req_i        = '1;
        operator_i   = '0;
        op_a_i       = '0;
        op_b_i       = '0;
        op_c_i       = '0;
        dot_signed_i = '0;
`ifdef DSP_MULT_ARB_PERF_EN
        perf_clr_i   = 1'b0;
`endif
        #2;
        check("rst_gnt", {28'b0, gnt_o}, 32'h0);
        check("rst_rvalid", {28'b0, rvalid_o}, 32'h0);
        check("rst_result", result_o, 32'h0);
        check("rst_busy", {31'b0, busy_o}, 32'h0);
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        req_i = '0;
        next_cycle();

        // All four requesters contend; grants rotate starting from index 0.
        for (int i = 0; i < NB_REQ; i++) begin
            set_op(i, MUL_DOT8, 32'h0101_0101, 32'h0101_0101 * (i + 1), 32'(i), 2'b00);
        end
        for (int k = 0; k < 8; k++) begin
            issue($sformatf("rr_gnt_%0d", k), REQ_TAB[k], GNT_TAB[k], RES_TAB[k], 1'b1);
        end
        req_i = '0;
        next_cycle();
        next_cycle();
        next_cycle();
`ifdef DSP_MULT_ARB_PERF_EN
        check("perf_busy_rr", perf_busy_o, 32'd8);
        check("perf_conflict_rr", perf_conflict_o, 32'd7);
        perf_clr_i = 1'b1;
`endif

        // Single signed DOT8 with accumulator: 4+3+2+1+10.
        set_op(1, MUL_DOT8, 32'h0102_0304, 32'h0101_0101, 32'd10, 2'b11);
        issue("dot8_gnt", 4'b0010, 4'b0010, 32'd20, 1'b1);
`ifdef DSP_MULT_ARB_PERF_EN
        perf_clr_i = 1'b0;
        check("perf_busy_clr", perf_busy_o, 32'd0);
        check("perf_conflict_clr", perf_conflict_o, 32'd0);
`endif

        // DOT16 signed: -1*3 + 2*4 = 5; unsigned: 65535*3 + 8 = 0x00030005.
        set_op(0, MUL_DOT16, 32'hFFFF_0002, 32'h0003_0004, 32'd0, 2'b11);
        issue("dot16s_gnt", 4'b0001, 4'b0001, 32'd5, 1'b1);
        set_op(0, MUL_DOT16, 32'hFFFF_0002, 32'h0003_0004, 32'd0, 2'b00);
        issue("dot16u_gnt", 4'b0001, 4'b0001, 32'h0003_0005, 1'b1);
        req_i = '0;
        next_cycle();
        next_cycle();
        next_cycle();

        // Back-to-back non-dot operator from requester 2 returns zero results.
        set_op(2, MUL_MAC32, 32'd7, 32'd9, 32'd5, 2'b11);
        for (int i = 0; i < 3; i++) begin
            issue($sformatf("mac_gnt_%0d", i), 4'b0100, 4'b0100, 32'd0, 1'b1);
            check($sformatf("mac_busy_%0d", i), {31'b0, busy_o}, 32'h1);
        end
        req_i = '0;
        next_cycle();
        check("mac_busy_tail", {31'b0, busy_o}, 32'h1);
        next_cycle();
        check("mac_idle", {31'b0, busy_o}, 32'h0);
        next_cycle();

        // Two ops in flight, then reset: neither may produce a result.
        set_op(1, MUL_DOT8, 32'h0101_0101, 32'h0101_0101, 32'd0, 2'b00);
        set_op(2, MUL_DOT8, 32'h0101_0101, 32'h0101_0101, 32'd0, 2'b00);
        issue("flush_gnt_a", 4'b0010, 4'b0010, 32'd0, 1'b0);
        issue("flush_gnt_b", 4'b0100, 4'b0100, 32'd0, 1'b0);
        check("flush_busy_pre", {31'b0, busy_o}, 32'h1);
        rst_i = 1'b1;
        req_i = 4'b1001;
        #1;
        check("flush_busy", {31'b0, busy_o}, 32'h0);
        check("flush_result", result_o, 32'h0);
        check("flush_rvalid", {28'b0, rvalid_o}, 32'h0);
        check("flush_gnt", {28'b0, gnt_o}, 32'h0);
        next_cycle();
        rst_i = 1'b0;
        issue("post_rst_gnt0", 4'b1001, 4'b0001, 32'h0003_0005, 1'b1);
        issue("post_rst_gnt3", 4'b1000, 4'b1000, 32'd19, 1'b1);
        req_i = '0;

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            next_cycle();
        end
        next_cycle();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
